// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: controlled 2-bit select sequencer for the incomp_case mux.
// Optional macro MUX_SEL_CODE3_EN adds code 3 to the sequence and drives sel_illegal.
module mux_sel_sequencer #(
    parameter int DWELL_W = 8,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ROUND_W-1:0] rounds,
    output logic [1:0]         sel,
    output logic               sel_strobe,
    output logic               busy,
    output logic               done,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               sel_illegal
);
`ifdef MUX_SEL_CODE3_EN
    localparam logic [1:0] LAST = 2'd3;
`else
    localparam logic [1:0] LAST = 2'd2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, nxt_state;
    logic [1:0]         nxt_sel;
    logic               nxt_strobe, nxt_busy, nxt_done;
    logic [ROUND_W-1:0] nxt_round, rounds_q, nxt_rounds, round_inc;
    logic [DWELL_W-1:0] dwell_q, nxt_dwell, cnt, nxt_cnt, dwell_eff;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign round_inc = round_cnt + ROUND_W'(1);

    // State and all outputs are registered; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            sel        <= '0;
            sel_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            round_cnt  <= '0;
            rounds_q   <= '0;
            dwell_q    <= '0;
            cnt        <= '0;
        end else begin
            state      <= nxt_state;
            sel        <= nxt_sel;
            sel_strobe <= nxt_strobe;
            busy       <= nxt_busy;
            done       <= nxt_done;
            round_cnt  <= nxt_round;
            rounds_q   <= nxt_rounds;
            dwell_q    <= nxt_dwell;
            cnt        <= nxt_cnt;
        end
    end

    // Next state and next register values; stop beats both start and code advance.
    always_comb begin
        nxt_state  = state;
        nxt_sel    = sel;
        nxt_strobe = 1'b0;
        nxt_busy   = busy;
        nxt_done   = 1'b0;
        nxt_round  = round_cnt;
        nxt_rounds = rounds_q;
        nxt_dwell  = dwell_q;
        nxt_cnt    = cnt;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    nxt_state  = S_RUN;
                    nxt_sel    = 2'd0;
                    nxt_strobe = 1'b1;
                    nxt_busy   = 1'b1;
                    nxt_round  = '0;
                    nxt_dwell  = dwell_eff;
                    nxt_rounds = rounds;
                    nxt_cnt    = dwell_eff;
                end
            end
            S_RUN: begin
                if (stop) begin
                    nxt_state = S_DONE;
                    nxt_sel   = 2'd0;
                    nxt_busy  = 1'b0;
                    nxt_done  = 1'b1;
                end else if (cnt == DWELL_W'(1)) begin
                    nxt_cnt = dwell_q;
                    if (sel == LAST) begin
                        nxt_round = round_inc;
                        nxt_sel   = 2'd0;
                        if (rounds_q != '0 && round_inc == rounds_q) begin
                            nxt_state = S_DONE;
                            nxt_busy  = 1'b0;
                            nxt_done  = 1'b1;
                        end else begin
                            nxt_strobe = 1'b1;
                        end
                    end else begin
                        nxt_sel    = sel + 2'd1;
                        nxt_strobe = 1'b1;
                    end
                end else begin
                    nxt_cnt = cnt - DWELL_W'(1);
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

`ifdef MUX_SEL_CODE3_EN
    // Flags the unmapped code so the mux's hold behaviour can be observed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_illegal <= 1'b0;
        else       sel_illegal <= (nxt_sel == 2'd3);
    end
`else
    assign sel_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: randomized and directed checks against an arithmetic model.
module tb_mux_sel_sequencer;
`ifdef MUX_SEL_CODE3_EN
    localparam int NC = 4;
`else
    localparam int NC = 3;
`endif

    logic       clk, reset, start, stop;
    logic [7:0] dwell;
    logic [3:0] rounds;
    logic [1:0] sel;
    logic       sel_strobe, busy, done, sel_illegal;
    logic [3:0] round_cnt;
    int total = 0;
    int bad = 0;

    mux_sel_sequencer #(.DWELL_W(8), .ROUND_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .dwell(dwell), .rounds(rounds), .sel(sel), .sel_strobe(sel_strobe),
        .busy(busy), .done(done), .round_cnt(round_cnt), .sel_illegal(sel_illegal)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int rc);
        chk({tag, ".sel"}, 32'(sel), 0);
        chk({tag, ".strobe"}, 32'(sel_strobe), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".round"}, 32'(round_cnt), rc);
        chk({tag, ".illegal"}, 32'(sel_illegal), 0);
    endtask

    // Expected behaviour at cycle k after the start edge: code k/de mod NC, pass k/(de*NC).
    task automatic run_seq(input int d, input int r, input int stop_at);
        int de, end_k, rc_end, code;
        de     = (d == 0) ? 1 : d;
        end_k  = (stop_at >= 0) ? stop_at + 1 : de * NC * r;
        rc_end = ((stop_at >= 0) ? stop_at / (de * NC) : r) % 16;
        dwell  = 8'(d);
        rounds = 4'(r);
        start  = 1;
        step();
        start  = 0;
        dwell  = 8'($urandom);
        rounds = 4'($urandom);
        for (int k = 0; k <= end_k; k++) begin
            if (k < end_k) begin
                code = (k / de) % NC;
                chk("run.sel", 32'(sel), code);
                chk("run.strobe", 32'(sel_strobe), (k % de == 0) ? 1 : 0);
                chk("run.busy", 32'(busy), 1);
                chk("run.done", 32'(done), 0);
                chk("run.round", 32'(round_cnt), (k / (de * NC)) % 16);
                chk("run.illegal", 32'(sel_illegal), (code == 3) ? 1 : 0);
                if (k == stop_at) stop = 1;
            end else begin
                chk("fin.sel", 32'(sel), 0);
                chk("fin.strobe", 32'(sel_strobe), 0);
                chk("fin.busy", 32'(busy), 0);
                chk("fin.done", 32'(done), 1);
                chk("fin.round", 32'(round_cnt), rc_end);
                chk("fin.illegal", 32'(sel_illegal), 0);
                start = 1;
            end
            step();
            stop  = 0;
            start = 0;
        end
        chk_idle("post", rc_end);
        step();
        chk_idle("post2", rc_end);
    endtask

    initial begin
        int d, r, s, de;
        reset = 1; start = 0; stop = 0; dwell = 0; rounds = 0;
        #12 reset = 0;
        for (int i = 0; i < 20; i++) begin
            chk_idle("reset", 0);
            step();
        end
        run_seq(2, 1, -1);
        run_seq(0, 2, -1);
        run_seq(3, 0, 7);
        dwell = 1; rounds = 1; start = 1; stop = 1;
        step();
        start = 0; stop = 0;
        chk_idle("startstop", 0);
        step();
        chk_idle("startstop2", 0);
        run_seq(1, 1, -1);
        dwell = 1; rounds = 0; start = 1;
        step();
        start = 0;
        step();
        step();
        chk("mid.sel", 32'(sel), 2);
        chk("mid.busy", 32'(busy), 1);
        #2 reset = 1;
        #1;
        chk_idle("async_reset", 0);
        #3 reset = 0;
        step();
        chk_idle("after_reset", 0);
        for (int i = 0; i < 10; i++) begin
            d  = $urandom_range(0, 4);
            r  = $urandom_range(0, 3);
            de = (d == 0) ? 1 : d;
            s  = -1;
            if (r == 0 || $urandom_range(0, 1) == 1)
                s = $urandom_range(0, de * NC * ((r == 0) ? 3 : r) - 1);
            run_seq(d, r, s);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
